usb_tx_scheduler: RTL

Sequencer and arbiter in front of the USB transmit state machine. It accepts handshake requests (ACK/NAK) from the receive-side protocol logic and DATA packet requests from the host-interface side. It grants one at a time, with handshake priority, and drives the `tx_packet` command and data size into the TX FSM. It holds the command until the FSM reports `tx_done`, enforces a minimum inter-packet gap, and aborts packets that never complete.

---
 rtl/usb_tx_scheduler_pkg.sv | 24 ++
 rtl/usb_tx_scheduler_if.sv | 34 +++
 rtl/usb_tx_scheduler_timer.sv | 35 +++
 rtl/usb_tx_scheduler.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/usb_tx_scheduler_pkg.sv
// Shared types and constants for the USB transmit path (scheduler, TX FSM, TX buffer).
package usb_tx_pkg;

  localparam int MAX_DATA_BYTES = 64;
  localparam int TIMER_WIDTH    = 13;

  typedef enum logic [1:0] {
    TXP_NONE = 2'd0,
    TXP_DATA = 2'd1,
    TXP_ACK  = 2'd2,
    TXP_NAK  = 2'd3
  } tx_packet_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_t;

  function automatic tx_packet_t hs_packet(input logic nak);
    return nak ? TXP_NAK : TXP_ACK;
  endfunction

endpackage

// File: rtl/usb_tx_scheduler_if.sv
// Request/grant and TX FSM command bundle between the scheduler and its neighbours.
interface usb_tx_scheduler_if;
  import usb_tx_pkg::*;

  logic       hs_req;
  logic       hs_nak;
  logic       data_req;
  logic [6:0] data_size;
  logic [6:0] buffer_occupancy;
  logic       tx_done;

  tx_packet_t tx_packet;
  logic [6:0] tx_packet_data_size;
  logic       hs_grant;
  logic       data_grant;
  logic       hs_done;
  logic       data_done;
  logic       tx_error;
  logic       flush_buffer;
  logic       tx_active;

  modport master (
    output hs_req, hs_nak, data_req, data_size, buffer_occupancy, tx_done,
    input  tx_packet, tx_packet_data_size, hs_grant, data_grant,
           hs_done, data_done, tx_error, flush_buffer, tx_active
  );

  modport slave (
    input  hs_req, hs_nak, data_req, data_size, buffer_occupancy, tx_done,
    output tx_packet, tx_packet_data_size, hs_grant, data_grant,
           hs_done, data_done, tx_error, flush_buffer, tx_active
  );

endinterface

// File: rtl/usb_tx_scheduler_timer.sv
// Shared up/down counter: counts down through the inter-packet gap, up for the SEND timeout.
module tx_sched_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  // Load wins over clear so a packet end can reload the gap in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end else if (dec) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == tc_val);

endmodule

// File: rtl/usb_tx_scheduler.sv
// Arbitrates handshake vs DATA transmit requests, holds the TX FSM command until done,
// enforces the inter-packet gap and aborts packets that never complete.
module usb_tx_scheduler #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_DATA_BYTES = usb_tx_pkg::MAX_DATA_BYTES
) (
  input logic               clk,
  input logic               rst,
  usb_tx_scheduler_if.slave bus
);
  import usb_tx_pkg::*;

  localparam logic [TIMER_WIDTH-1:0] GAP_LOAD = TIMER_WIDTH'(GAP_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TO_LAST  = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]             MAX_SZ   = 8'(MAX_DATA_BYTES);

  sched_state_t state_reg;
  tx_packet_t   tx_packet_reg;
  logic [6:0]   size_reg;
  logic         hs_grant_reg;
  logic         data_grant_reg;
  logic         hs_done_reg;
  logic         data_done_reg;
  logic         tx_error_reg;
  logic         flush_reg;
  logic         active_reg;

  logic hs_win;
  logic data_win;
  logic data_bad;
  logic send_end;

  logic                   tmr_clr;
  logic                   tmr_load;
  logic                   tmr_inc;
  logic                   tmr_dec;
  logic [TIMER_WIDTH-1:0] tmr_tc_val;
  logic                   tmr_tc;

  assign hs_win   = bus.hs_req;
  assign data_win = !bus.hs_req && bus.data_req && (bus.buffer_occupancy >= bus.data_size);
  assign data_bad = data_win && ({1'b0, bus.data_size} > MAX_SZ);
  assign send_end = bus.tx_done || tmr_tc;

  // Timer is held at zero in IDLE so SEND starts counting from 0 on the grant edge.
  always_comb begin
    tmr_clr    = 1'b0;
    tmr_load   = 1'b0;
    tmr_inc    = 1'b0;
    tmr_dec    = 1'b0;
    tmr_tc_val = '0;
    case (state_reg)
      ST_IDLE: begin
        tmr_clr  = 1'b1;
        tmr_load = data_bad;
      end
      ST_SEND: begin
        tmr_tc_val = TO_LAST;
        tmr_inc    = 1'b1;
        tmr_load   = send_end;
      end
      ST_GAP: begin
        tmr_dec = !tmr_tc;
      end
      default: ;
    endcase
  end

  tx_sched_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (GAP_LOAD),
    .inc      (tmr_inc),
    .dec      (tmr_dec),
    .tc_val   (tmr_tc_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      tx_packet_reg  <= TXP_NONE;
      size_reg       <= '0;
      hs_grant_reg   <= 1'b0;
      data_grant_reg <= 1'b0;
      hs_done_reg    <= 1'b0;
      data_done_reg  <= 1'b0;
      tx_error_reg   <= 1'b0;
      flush_reg      <= 1'b0;
      active_reg     <= 1'b0;
    end else begin
      hs_grant_reg   <= 1'b0;
      data_grant_reg <= 1'b0;
      hs_done_reg    <= 1'b0;
      data_done_reg  <= 1'b0;
      tx_error_reg   <= 1'b0;
      flush_reg      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (hs_win) begin
            hs_grant_reg  <= 1'b1;
            tx_packet_reg <= hs_packet(bus.hs_nak);
            active_reg    <= 1'b1;
            state_reg     <= ST_SEND;
          end else if (data_win) begin
            data_grant_reg <= 1'b1;
            active_reg     <= 1'b1;
            if (data_bad) begin
              tx_error_reg <= 1'b1;
              flush_reg    <= 1'b1;
              state_reg    <= ST_GAP;
            end else begin
              tx_packet_reg <= TXP_DATA;
              size_reg      <= bus.data_size;
              state_reg     <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          // Completion takes precedence when tx_done lands on the expiry cycle.
          if (bus.tx_done) begin
            tx_packet_reg <= TXP_NONE;
            data_done_reg <= (tx_packet_reg == TXP_DATA);
            hs_done_reg   <= (tx_packet_reg != TXP_DATA);
            state_reg     <= ST_GAP;
          end else if (tmr_tc) begin
            tx_packet_reg <= TXP_NONE;
            tx_error_reg  <= 1'b1;
            flush_reg     <= (tx_packet_reg == TXP_DATA);
            state_reg     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_tc) begin
            active_reg <= 1'b0;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_packet           = tx_packet_reg;
  assign bus.tx_packet_data_size = size_reg;
  assign bus.hs_grant            = hs_grant_reg;
  assign bus.data_grant          = data_grant_reg;
  assign bus.hs_done             = hs_done_reg;
  assign bus.data_done           = data_done_reg;
  assign bus.tx_error            = tx_error_reg;
  assign bus.flush_buffer        = flush_reg;
  assign bus.tx_active           = active_reg;

endmodule
